// File: rtl/accelerant_pkg.sv
// Shared Accelerant definitions: PE instruction encodings, the legality check
// used by the programming master, and the loader FSM state type.
package accelerant_pkg;

  localparam logic [3:0] INSTR_FADD    = 4'b0000;
  localparam logic [3:0] INSTR_FMUL    = 4'b0001;
  localparam logic [3:0] INSTR_REGLOAD = 4'b0010;
  localparam logic [3:0] INSTR_FMA     = 4'b0011;
  localparam logic [3:0] INSTR_SYS_FMA = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_FINISH = 2'd2
  } loader_state_t;

  // Register-only load is legal: the PE keeps its configuration and latches data.
  function automatic logic is_legal_instr(input logic [3:0] instr);
    logic ok;
    case (instr)
      INSTR_FADD, INSTR_FMUL, INSTR_REGLOAD, INSTR_FMA, INSTR_SYS_FMA: ok = 1'b1;
      default:                                                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/pe_load_decoder.sv
// Combinational PE target decode: index or broadcast to a strobe vector,
// plus a flag saying the target actually exists.
module pe_load_decoder
  import accelerant_pkg::*;
#(
  parameter int NUM_PE = 16,
  parameter int IDX_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic [IDX_W-1:0]  i_pe_idx,
  input  logic              i_broadcast,
  output logic [NUM_PE-1:0] o_load_vec,
  output logic              o_idx_ok
);

  logic [NUM_PE-1:0] w_hit;

  // One-hot match; an out-of-range index matches nothing.
  always_comb begin
    w_hit = {NUM_PE{1'b0}};
    for (int i = 0; i < NUM_PE; i++) begin
      w_hit[i] = (i_pe_idx == IDX_W'(i));
    end
  end

  assign o_load_vec = i_broadcast ? {NUM_PE{1'b1}} : w_hit;
  assign o_idx_ok   = i_broadcast | (|w_hit);

endmodule

// File: rtl/pe_config_loader.sv
// Programming master for the Accelerant mesh: turns a valid/ready stream of
// configuration entries into single-cycle PE load pulses with status reporting.
module pe_config_loader
  import accelerant_pkg::*;
#(
  parameter int NUM_PE = 16,
  parameter int IDX_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [IDX_W-1:0]  cfg_pe_idx,
  input  logic              cfg_broadcast,
  input  logic [3:0]        cfg_instruction,
  input  logic [31:0]       cfg_data,
  input  logic              cfg_last,
  output logic [NUM_PE-1:0] pe_load,
  output logic [3:0]        pe_instruction,
  output logic [31:0]       pe_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       entries_loaded
);

  loader_state_t     r_state;
  logic [NUM_PE-1:0] w_load_vec;
  logic              w_idx_ok;
  logic              w_accept;
  logic              w_legal;

  pe_load_decoder #(
    .NUM_PE (NUM_PE),
    .IDX_W  (IDX_W)
  ) u_decoder (
    .i_pe_idx    (cfg_pe_idx),
    .i_broadcast (cfg_broadcast),
    .o_load_vec  (w_load_vec),
    .o_idx_ok    (w_idx_ok)
  );

  assign w_accept = cfg_valid & cfg_ready;
  assign w_legal  = is_legal_instr(cfg_instruction) & w_idx_ok;

  // Session FSM; every output is registered and cfg_ready tracks the LOAD state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      cfg_ready      <= 1'b0;
      pe_load        <= {NUM_PE{1'b0}};
      pe_instruction <= 4'd0;
      pe_data        <= 32'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      entries_loaded <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          pe_load <= {NUM_PE{1'b0}};
          done    <= 1'b0;
          if (start && !abort) begin
            r_state        <= ST_LOAD;
            cfg_ready      <= 1'b1;
            busy           <= 1'b1;
            error          <= 1'b0;
            entries_loaded <= 16'd0;
          end else begin
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            // The entry handshaken alongside abort is discarded without trace.
            r_state   <= ST_IDLE;
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pe_load   <= {NUM_PE{1'b0}};
          end else if (w_accept) begin
            if (w_legal) begin
              pe_load        <= w_load_vec;
              pe_instruction <= cfg_instruction;
              pe_data        <= cfg_data;
              if (entries_loaded != 16'hFFFF) begin
                entries_loaded <= entries_loaded + 16'd1;
              end else begin
                entries_loaded <= entries_loaded;
              end
            end else begin
              pe_load <= {NUM_PE{1'b0}};
              error   <= 1'b1;
            end
            if (cfg_last) begin
              r_state   <= ST_FINISH;
              cfg_ready <= 1'b0;
              done      <= 1'b1;
            end else begin
              done <= 1'b0;
            end
          end else begin
            pe_load <= {NUM_PE{1'b0}};
            done    <= 1'b0;
          end
        end
        ST_FINISH: begin
          r_state   <= ST_IDLE;
          cfg_ready <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          pe_load   <= {NUM_PE{1'b0}};
        end
        default: begin
          r_state   <= ST_IDLE;
          cfg_ready <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          pe_load   <= {NUM_PE{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_config_loader.sv
// Directed self-checking bench for pe_config_loader with hand-computed expectations.
module tb_pe_config_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [3:0]  cfg_pe_idx;
  logic        cfg_broadcast;
  logic [3:0]  cfg_instruction;
  logic [31:0] cfg_data;
  logic        cfg_last;
  logic [15:0] pe_load;
  logic [3:0]  pe_instruction;
  logic [31:0] pe_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] entries_loaded;

  int n_checks = 0;
  int n_pass   = 0;

  pe_config_loader #(.NUM_PE(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .abort           (abort),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_pe_idx      (cfg_pe_idx),
    .cfg_broadcast   (cfg_broadcast),
    .cfg_instruction (cfg_instruction),
    .cfg_data        (cfg_data),
    .cfg_last        (cfg_last),
    .pe_load         (pe_load),
    .pe_instruction  (pe_instruction),
    .pe_data         (pe_data),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .entries_loaded  (entries_loaded)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] idx, input logic bc, input logic [3:0] instr,
                      input logic [31:0] data, input logic last);
    cfg_valid       = 1'b1;
    cfg_pe_idx      = idx;
    cfg_broadcast   = bc;
    cfg_instruction = instr;
    cfg_data        = data;
    cfg_last        = last;
  endtask

  task automatic begin_session();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0;
    cfg_pe_idx = 4'd0; cfg_broadcast = 1'b0; cfg_instruction = 4'd0;
    cfg_data = 32'd0; cfg_last = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_pe_load", 32'(pe_load), 32'h0);
    check("rst_ready", 32'(cfg_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_data", pe_data, 32'h0);
    check("rst_count", 32'(entries_loaded), 32'h0);
    reset = 1'b1;
    tick();
    check("idle_ready", 32'(cfg_ready), 32'h0);

    // Basic load to PE 5
    begin_session();
    check("t1_ready", 32'(cfg_ready), 32'h1);
    check("t1_busy", 32'(busy), 32'h1);
    send(4'd5, 1'b0, 4'b0001, 32'h3F800000, 1'b1);
    tick();
    cfg_valid = 1'b0;
    check("t1_pe_load", 32'(pe_load), 32'h0020);
    check("t1_instr", 32'(pe_instruction), 32'h1);
    check("t1_data", pe_data, 32'h3F800000);
    check("t1_done", 32'(done), 32'h1);
    check("t1_count", 32'(entries_loaded), 32'h1);
    tick();
    check("t1_busy_end", 32'(busy), 32'h0);
    check("t1_done_end", 32'(done), 32'h0);
    check("t1_load_end", 32'(pe_load), 32'h0);
    check("t1_data_hold", pe_data, 32'h3F800000);

    // Back-to-back entries to PEs 0..3
    begin_session();
    for (int i = 0; i < 4; i++) begin
      send(4'(i), 1'b0, 4'b0000, 32'(100 + i), (i == 3));
      tick();
      check("t2_pe_load", 32'(pe_load), 32'(1 << i));
      check("t2_data", pe_data, 32'(100 + i));
      check("t2_done", 32'(done), (i == 3) ? 32'h1 : 32'h0);
    end
    cfg_valid = 1'b0;
    check("t2_count", 32'(entries_loaded), 32'h4);
    tick();
    check("t2_busy_end", 32'(busy), 32'h0);

    // Broadcast register-only load; index is ignored
    begin_session();
    send(4'd3, 1'b1, 4'b0010, 32'hDEADBEEF, 1'b1);
    tick();
    cfg_valid = 1'b0;
    check("t3_pe_load", 32'(pe_load), 32'hFFFF);
    check("t3_instr", 32'(pe_instruction), 32'h2);
    check("t3_data", pe_data, 32'hDEADBEEF);
    check("t3_count", 32'(entries_loaded), 32'h1);
    tick();
    check("t3_load_end", 32'(pe_load), 32'h0);

    // Illegal instruction dropped, then a legal systolic FMA to PE 15
    begin_session();
    send(4'd2, 1'b0, 4'b0111, 32'h11111111, 1'b0);
    tick();
    check("t4_drop_load", 32'(pe_load), 32'h0);
    check("t4_error", 32'(error), 32'h1);
    check("t4_drop_count", 32'(entries_loaded), 32'h0);
    send(4'd15, 1'b0, 4'b1010, 32'h22222222, 1'b1);
    tick();
    cfg_valid = 1'b0;
    check("t4_pe_load", 32'(pe_load), 32'h8000);
    check("t4_done", 32'(done), 32'h1);
    check("t4_count", 32'(entries_loaded), 32'h1);
    check("t4_error_sticky", 32'(error), 32'h1);
    tick();
    check("t4_error_hold", 32'(error), 32'h1);

    // New session clears error; backpressure then abort with a handshake
    begin_session();
    check("t5_error_clr", 32'(error), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_idle_load", 32'(pe_load), 32'h0);
      check("t5_ready", 32'(cfg_ready), 32'h1);
    end
    send(4'd1, 1'b0, 4'b0000, 32'h33333333, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    cfg_valid = 1'b0;
    check("t5_abort_load", 32'(pe_load), 32'h0);
    check("t5_abort_done", 32'(done), 32'h0);
    check("t5_abort_busy", 32'(busy), 32'h0);
    check("t5_abort_ready", 32'(cfg_ready), 32'h0);
    check("t5_abort_count", 32'(entries_loaded), 32'h0);
    tick();
    check("t5_stay_idle", 32'(cfg_ready), 32'h0);

    // abort beats start from IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("t5_abort_wins_busy", 32'(busy), 32'h0);
    check("t5_abort_wins_ready", 32'(cfg_ready), 32'h0);

    // Asynchronous reset mid-session with an entry in flight
    begin_session();
    send(4'd0, 1'b0, 4'b0100, 32'h0, 1'b0);
    tick();
    check("t6_error_set", 32'(error), 32'h1);
    send(4'd7, 1'b0, 4'b0011, 32'h44444444, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_busy", 32'(busy), 32'h0);
    check("t6_async_error", 32'(error), 32'h0);
    check("t6_async_ready", 32'(cfg_ready), 32'h0);
    tick();
    check("t6_no_load", 32'(pe_load), 32'h0);
    reset = 1'b1;
    tick(); tick();
    check("t6_need_start", 32'(cfg_ready), 32'h0);
    check("t6_still_no_load", 32'(pe_load), 32'h0);
    cfg_valid = 1'b0;
    begin_session();
    check("t6_ready_after_start", 32'(cfg_ready), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
